dm_param: RTL

DM_PARAM -- requirements
Module: dm_param

---
 rtl/dm_param.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dm_param.sv
// Parameterised single-port-pair data memory with a power-up/on-demand clear sweep.
// Define DM_WR_FWD_EN for write-first behaviour on same-address read/write (default: read-first).
module dm_param #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 11,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  output logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              err
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              clr_we, acc, err_clr;
  logic              w_in, r_in;
  logic [IDX_W-1:0]  widx, ridx, cidx;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  assign w_in = ({1'b0, waddr} < DEPTH_A);
  assign r_in = ({1'b0, raddr} < DEPTH_A);
  assign widx = waddr[IDX_W-1:0];
  assign ridx = raddr[IDX_W-1:0];
  assign cidx = cnt_reg[IDX_W-1:0];
  assign busy = (state_reg == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // acc marks a cycle in which user reads/writes are honoured.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_we     = 1'b0;
    acc        = 1'b0;
    err_clr    = 1'b0;
    case (state_reg)
      CLEAR: begin
        clr_we = 1'b1;
        if (init_req) begin
          cnt_next = '0;
        end else if (cnt_reg == LAST) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      READY: begin
        if (init_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
          err_clr    = 1'b1;
        end else begin
          acc = 1'b1;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // Memory array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cidx] <= INIT_VAL;
    end else if (acc && we && w_in) begin
      mem[widx] <= din;
    end
  end

`ifdef DM_WR_FWD_EN
  assign rd_data = (we && (waddr == raddr)) ? din : mem[ridx];
`else
  assign rd_data = mem[ridx];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout   <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= acc && re;
      if (acc && re) begin
        dout <= r_in ? rd_data : '0;
      end
      if (err_clr) begin
        err <= 1'b0;
      end else if (acc && ((we && !w_in) || (re && !r_in))) begin
        err <= 1'b1;
      end
    end
  end

endmodule
